// File: rtl/dut_out_mon_pkg.sv
// ============================================================================
//  Module      : dut_out_mon_pkg
//  Description : Shared types, constants and helpers for dut_out_monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dut_out_mon_pkg;

    localparam int MON_WIDTH = 4;
    localparam logic [7:0] CNT_MAX = 8'hFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2
    } mon_state_e;

    typedef struct packed {
        logic [MON_WIDTH-1:0] data;
        logic                 match;
    } mon_entry_t;

    // Saturating increment used by the pass/fail counters.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == CNT_MAX) ? v : v + 8'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mon_fifo.sv
// ============================================================================
//  Module      : mon_fifo
//  Description : Synchronous FIFO with extra-MSB pointers and a
//                combinational head output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mon_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [DW-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic          w_push_eff;
    logic          w_pop_eff;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // A pop frees a slot on the same edge, so a push into a full FIFO that is
    // also popping is still accepted.
    assign w_pop_eff  = pop && !empty;
    assign w_push_eff = push && (!full || w_pop_eff);

    assign head = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push_eff) begin
                r_mem[r_wr_ptr[AW-1:0]] <= push_data;
                r_wr_ptr                <= r_wr_ptr + 1'b1;
            end
            if (w_pop_eff) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/dut_out_monitor.sv
// ============================================================================
//  Module      : dut_out_monitor
//  Description : Settle-then-capture sampler of a DUT output with result FIFO
//                and saturating pass/fail counters. Optional checks enabled
//                by defining DUT_OUT_MONITOR_ASSERT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dut_out_monitor
    import dut_out_mon_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int DEPTH      = 4,
    parameter int SETTLE_CYC = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] dut_out,
    input  logic [WIDTH-1:0] exp_val,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_match,
    output logic             full,
    output logic             overflow,
    output logic [7:0]       pass_cnt,
    output logic [7:0]       fail_cnt,
    output logic             busy
);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_SETTLE  = 2'd1;
    localparam logic [1:0] c_ST_CAPTURE = 2'd2;
    localparam logic [3:0] c_SETTLE_LD  = 4'(SETTLE_CYC - 1);

    logic [1:0]       r_state;
    logic [3:0]       r_cnt;
    logic [7:0]       r_pass_cnt;
    logic [7:0]       r_fail_cnt;
    logic             r_overflow;

    logic             w_push;
    logic             w_pop;
    logic             w_match;
    logic             w_full;
    logic             w_empty;
    logic [WIDTH:0]   w_head;

    assign w_push  = (r_state == c_ST_CAPTURE);
    assign w_match = (dut_out == exp_val);
    assign w_pop   = !w_empty && rd_ready;

    mon_fifo #(
        .DEPTH (DEPTH),
        .DW    (WIDTH + 1)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data ({dut_out, w_match}),
        .pop       (w_pop),
        .full      (w_full),
        .empty     (w_empty),
        .head      (w_head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (sample_en) begin
                        r_state <= c_ST_SETTLE;
                        r_cnt   <= c_SETTLE_LD;
                    end
                end
                c_ST_SETTLE: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= c_ST_CAPTURE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_ST_CAPTURE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Counters see every capture, even ones the FIFO has to drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
            r_overflow <= 1'b0;
        end else if (w_push) begin
            if (w_match) begin
                r_pass_cnt <= sat_inc(r_pass_cnt);
            end else begin
                r_fail_cnt <= sat_inc(r_fail_cnt);
            end
            if (w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

`ifdef DUT_OUT_MONITOR_ASSERT_EN
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            if (!w_match) begin
                $error("dut_out_monitor: captured %0h expected %0h at %0t",
                       dut_out, exp_val, $time);
            end
            assert (!(w_full && !w_pop))
                else $error("dut_out_monitor: push while full at %0t", $time);
        end
    end
`else
    // Checks compiled out; datapath is unchanged.
`endif

    assign rd_valid = !w_empty;
    assign rd_data  = w_head[WIDTH:1];
    assign rd_match = w_head[0];
    assign full     = w_full;
    assign overflow = r_overflow;
    assign pass_cnt = r_pass_cnt;
    assign fail_cnt = r_fail_cnt;
    assign busy     = (r_state != c_ST_IDLE);

endmodule

`default_nettype wire

// File: doc/dut_out_monitor.md
# dut_out_monitor

Clocked sampling stage that sits directly downstream of the DUT output and replaces race-prone time-zero checks. On request it waits a fixed settle interval, captures the DUT output, compares it against an expected value, and queues the result. Results are drained through a valid/ready interface, and the block keeps saturating pass/fail counters for the testbench top.

## Interface
Parameters:
- WIDTH, 4, width of the DUT output and the expected value
- DEPTH, 4, result FIFO entries; must be a power of two, minimum 2
- SETTLE_CYC, 1, cycles waited between accepting a request and capturing; range 1..15

Ports:
- clk  in  1  single clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- sample_en  in  1  capture request; accepted only in IDLE
- dut_out  in  WIDTH  DUT output under observation
- exp_val  in  WIDTH  expected value; sampled on the same edge as dut_out
- rd_ready  in  1  consumer ready
- rd_valid  out  1  FIFO non-empty
- rd_data  out  WIDTH  captured value at FIFO head
- rd_match  out  1  head entry matched exp_val
- full  out  1  FIFO holds DEPTH entries
- overflow  out  1  sticky; a capture was dropped
- pass_cnt  out  8  saturating count of matching captures
- fail_cnt  out  8  saturating count of mismatching captures
- busy  out  1  FSM is not in IDLE

## Operation
- FSM states: IDLE, SETTLE, CAPTURE.
- IDLE → SETTLE on an edge where sample_en=1. The settle counter loads SETTLE_CYC-1.
- SETTLE: the counter decrements each edge. SETTLE → CAPTURE on the edge where the counter is 0.
- CAPTURE → IDLE on the next edge. On that same edge:
  - dut_out and exp_val are sampled.
  - match = (dut_out == exp_val).
  - The entry {dut_out, match} is pushed to the FIFO.
  - pass_cnt increments if match=1, otherwise fail_cnt increments.
- sample_en is ignored outside IDLE. Requests are not queued.
- Both counters saturate at 255 and do not wrap.
- Counters update on every capture, including dropped ones.
- A push when full and not popping drops the entry and sets overflow. overflow clears only on rst.
- A pop occurs on an edge where rd_valid=1 and rd_ready=1.
- FIFO pointers are log2(DEPTH)+1 bits. full and empty are derived from the MSB compare.

## Timing
- Reset values: FSM=IDLE, FIFO empty, rd_valid=0, rd_data=0, rd_match=0, full=0, overflow=0, pass_cnt=0, fail_cnt=0, busy=0.
- sample_en seen at edge k: capture edge is k+SETTLE_CYC+1, and rd_valid=1 after that edge. With SETTLE_CYC=1, the capture edge is k+2.
- busy is high from edge k through the capture edge.
- Minimum spacing between accepted requests is SETTLE_CYC+2 edges.
- rd_data and rd_match come combinationally from the FIFO head register; there is no output register.
- Push and pop on the same edge when full: both happen, the entry is not dropped, and full stays 1.
- Push and pop on the same edge when empty: no pop occurs (rd_valid=0), and the push is stored.
- rst asserted mid-SETTLE or mid-CAPTURE: the pending capture is discarded and all state returns to reset values on that edge.
- rst has priority over every other input.

## Configuration
- Macro name: DUT_OUT_MONITOR_ASSERT_EN.
- When defined: every mismatching capture issues $error with the captured value, the expected value and $time.
- When defined: an immediate assertion fires when a push occurs while full.
- When undefined: no assertions and no messages. Functional behaviour is identical in both cases.

## Structure
- Package dut_out_mon_pkg holds:
  - the mon_state_e enum (IDLE, SETTLE, CAPTURE)
  - the mon_entry_t struct, parameterised by WIDTH through a localparam default of 4
  - localparam CNT_MAX = 8'hFF
- Sub-module mon_fifo: synchronous FIFO with parameters DEPTH and a data width, exposing push, pop, full, empty and head.
- The top holds the FSM, the settle counter, the comparator and the counters.

## Test plan
- Reset, then dut_out=2, exp_val=2, one sample_en pulse → rd_valid rises 2 edges later with rd_data=2, rd_match=1, pass_cnt=1.
- dut_out=5, exp_val=2 → rd_match=0, fail_cnt=1, pass_cnt unchanged. With the macro defined, exactly one $error.
- rd_ready=0, five accepted captures (DEPTH=4) → full=1 after the fourth, overflow=1 after the fifth. Draining yields exactly 4 entries in order.
- sample_en held high for 10 cycles → captures only on every third edge (SETTLE_CYC=1), and busy toggles accordingly.
- rst pulsed on the SETTLE edge → no entry is pushed, counters stay 0, and the FSM is in IDLE on the next edge.
- 260 matching captures with continuous draining → pass_cnt reads 255 and does not wrap.
